// File: rtl/mux_nch_scan_if.sv
// Bundle of the data, select/mask controls and tagged output of the scanning channel mux.
// Latency: none (wires only).
// Backpressure: none; the consumer samples every cycle and qualifies each sample with Y_VALID.
interface mux_nch_scan_if #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic [N*W-1:0] D;
    logic [SW-1:0]  S;
    logic           MODE;
    logic           EN;
    logic [N-1:0]   MASK;
    logic [W-1:0]   Y;
    logic           Y_VALID;
    logic [SW-1:0]  CH;
    logic           WRAP;

    modport master (
        output D, S, MODE, EN, MASK,
        input  Y, Y_VALID, CH, WRAP
    );

    modport slave (
        input  D, S, MODE, EN, MASK,
        output Y, Y_VALID, CH, WRAP
    );
endinterface

// File: rtl/mux_nch_scan.sv
// Registered N-channel mux with manual select or masked round-robin scan with a dwell time.
// Latency: one cycle from D/S/MASK/MODE/EN to Y/CH/Y_VALID/WRAP.
// Backpressure: none; EN=0 freezes Y/CH/dwell count and drops Y_VALID.
module mux_nch_scan #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic         clk,
    input  logic         rst,
    mux_nch_scan_if.slave bus
);
    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [W-1:0]   y_q,     y_d;
    logic [SW-1:0]  ch_q,    ch_d;
    logic           valid_q, valid_d;
    logic           wrap_q,  wrap_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [CW-1:0]  cnt_eff;

    logic           s_ok;
    logic           cur_ok;
    logic [W-1:0]   d_s;
    logic [W-1:0]   d_cur;
    logic [W-1:0]   d_nxt;

    logic [2*N-1:0] mask_rot;
    int             step;
    int             tgt;
    logic [SW-1:0]  nxt_ch;
    logic           nxt_wrap;

    function automatic logic [W-1:0] pick_data(input logic [N*W-1:0] d, input logic [SW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SW'(i)) r = d[i*W +: W];
        end
        return r;
    endfunction

    // Indices >= N (possible when N is not a power of two) are never usable.
    function automatic logic pick_mask(input logic [N-1:0] m, input logic [SW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (idx == SW'(i)) r = m[i];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state follows the mode controls sampled at this edge
    always_comb begin
        state_d = ST_IDLE;
        if (bus.EN) state_d = bus.MODE ? ST_SCAN : ST_MANUAL;
    end

    always_comb begin
        s_ok   = pick_mask(bus.MASK, bus.S);
        cur_ok = pick_mask(bus.MASK, ch_q);
        d_s    = pick_data(bus.D, bus.S);
        d_cur  = pick_data(bus.D, ch_q);
        d_nxt  = pick_data(bus.D, nxt_ch);
    end

    // Upward search with wrap: rotate a doubled mask so bit k-1 is channel (ch+k) mod N,
    // then take the lowest set bit. step=N lands back on ch itself (single-channel case).
    always_comb begin
        mask_rot = {bus.MASK, bus.MASK} >> (int'(ch_q) + 1);
        step     = N;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask_rot[k]) step = k + 1;
        end
        tgt      = int'(ch_q) + step;
        nxt_wrap = (tgt >= N);
        if (tgt >= N) tgt = tgt - N;
        nxt_ch   = SW'(tgt);
    end

    // Entering scan from manual always starts a fresh dwell period.
    assign cnt_eff = (state_q == ST_MANUAL) ? '0 : cnt_q;

    // Output / datapath decode for the state being entered at this edge
    always_comb begin
        y_d     = y_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        case (state_d)
            ST_MANUAL: begin
                cnt_d = '0;
                if (s_ok) begin
                    ch_d    = bus.S;
                    y_d     = d_s;
                    valid_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (bus.MASK == '0) begin
                    cnt_d = '0;
                end else if (!cur_ok || cnt_eff == CW'(DWELL - 1)) begin
                    ch_d    = nxt_ch;
                    y_d     = d_nxt;
                    valid_d = 1'b1;
                    wrap_d  = nxt_wrap;
                    cnt_d   = '0;
                end else begin
                    y_d     = d_cur;
                    valid_d = 1'b1;
                    cnt_d   = cnt_eff + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Y       = y_q;
    assign bus.Y_VALID = valid_q;
    assign bus.CH      = ch_q;
    assign bus.WRAP    = wrap_q;
endmodule

// File: doc/mux_nch_scan.md
# mux_nch_scan

Parametrised, registered N-channel, W-bit multiplexer with a manual-select mode and an automatic round-robin scan mode. Scan mode has a programmable dwell time and a per-channel enable mask. It replaces fixed 4-to-1 combinational muxes wherever a datapath must time-share one output between several sources. The output carries a valid flag, the current channel index and a wrap pulse, so downstream logic can tag each sample.

## Interface
- W, 8: data width per channel
- N, 4: channel count, 2..16; any value allowed, not only powers of two
- SW, 2: select/index width; must equal ceil(log2(N))
- DWELL, 4: cycles each channel is held in scan mode, ≥1

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- D  in  N*W  flattened channel data; channel i at D[i*W +: W]
- S  in  SW  manual channel select
- MODE  in  1  0 = manual, 1 = scan
- EN  in  1  advance/update enable
- MASK  in  N  per-channel enable; bit i = 1 means channel i is usable
- Y  out  W  registered selected data
- Y_VALID  out  1  Y holds a sample from a usable channel
- CH  out  SW  channel index that produced the current Y
- WRAP  out  1  one-cycle pulse when the scan index wraps past N-1

## Operation
- State machine has three states:
  - IDLE when EN=0.
  - MANUAL when EN=1 and MODE=0.
  - SCAN when EN=1 and MODE=1.
- IDLE:
  - Y, CH and the dwell counter hold.
  - Y_VALID = 0 and WRAP = 0.
- MANUAL, each cycle:
  - If S < N and MASK[S] = 1: load CH <= S, Y <= D[S], Y_VALID <= 1.
  - Otherwise: Y and CH hold, Y_VALID <= 0.
  - The dwell counter is held at 0.
- SCAN:
  - Each cycle: Y <= D[CH_next], CH <= CH_next, Y_VALID <= MASK[CH_next].
  - The dwell counter counts 0..DWELL-1.
  - When the counter reaches DWELL-1, CH_next is the next index above CH, searching upward with wrap, whose MASK bit is 1. The counter then returns to 0.
  - If the current CH becomes masked mid-dwell, the channel advances on the next cycle and the counter resets.
  - If MASK = 0: CH holds, Y holds, Y_VALID <= 0, counter resets.
  - If the only set mask bit is the current CH: CH stays, and WRAP still pulses each dwell period.
- WRAP is 1 in the same cycle CH updates, whenever the search passed from index N-1 to index 0 or beyond.
- Mode changes:
  - MANUAL→SCAN: the scan starts from the current CH with the counter at 0. The first advance comes DWELL cycles later.
  - SCAN→MANUAL: CH takes S on the first MANUAL cycle.
- D is sampled only on the clock edge. No combinational path exists from the inputs to Y.

## Timing
- Reset values: Y = 0, Y_VALID = 0, CH = 0, WRAP = 0, dwell counter = 0, state IDLE.
- Reset takes effect at the first rising edge with rst = 1 and overrides EN and MODE.
- Reset mid-scan: the next cycle after rst is released, with EN = 1 and MODE = 1, restarts at CH = 0, or at the first set MASK bit if bit 0 is clear.
- Latency is one cycle. A value on D/S/MASK at edge t appears on Y/CH/Y_VALID after edge t.
- Y, CH and Y_VALID are always mutually consistent within one cycle.
- In SCAN with all channels unmasked and EN held high, CH changes every DWELL cycles. The sequence is 0,1,…,N-1,0 with WRAP high on the cycle CH returns to 0.
- Simultaneous events:
  - A mask change and a dwell expiry in the same cycle: the new MASK is used for the search.
  - rst has priority over everything.
- Counter width is ceil(log2(DWELL+1)). No overflow is possible.

## Test plan
- Reset: rst=1 for 2 cycles with D=all 0xFF → Y=0x00, Y_VALID=0, CH=0, WRAP=0. Release with EN=0 → outputs unchanged.
- Manual, N=4, W=8:
  - D={ch3=0x00, ch2=0x01, ch1=0x02, ch0=0x03}, MASK=4'b1111, S swept 0,1,2,3, one value per 10 cycles → Y=0x03,0x02,0x01,0x00, each one cycle after S changes. CH tracks S. Y_VALID=1.
  - MASK[2]=0 with S=2 → Y holds its previous value, Y_VALID=0.
- Scan, DWELL=4, MASK=4'b1111, EN=1 for 20 cycles → CH changes every 4 cycles: 0,1,2,3,0. WRAP is high for exactly one cycle, at CH=0 after CH=3. Y matches the D channel for CH.
- Scan with MASK=4'b1010 → CH sequence 1,3,1,3. WRAP on each 3→1 transition.
  - Clear MASK[3] while CH=3 → CH moves to 1 on the next cycle and the counter restarts.
  - MASK=0 → Y_VALID=0 and CH holds.
- Non-power-of-two N=3 (SW=2): manual S=3 → Y_VALID=0, Y holds. Scan → CH sequence 0,1,2,0 with WRAP on 2→0.
- Mode and reset interplay:
  - Switch SCAN→MANUAL with S=2 mid-dwell → CH=2 on the next cycle.
  - Assert rst mid-scan while CH=2 → all outputs return to reset values on the next edge, and scanning restarts at CH=0 after release.
